// File: rtl/row_occupancy_tracker_if.sv
// Command/response bus between the placement controller (master) and the row occupancy tracker (slave).
// Both channels transfer on a rising edge where valid && ready; the producer holds its fields stable until then.
interface row_occupancy_tracker_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_op;
    logic [3:0] cmd_str_id;
    logic [4:0] cmd_width;
    logic       rsp_valid;
    logic       rsp_ready;
    logic       rsp_ok;
    logic [4:0] rsp_height;
    logic [4:0] rsp_free;
    logic       all_empty;

    modport master (
        output cmd_valid, cmd_op, cmd_str_id, cmd_width, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_ok, rsp_height, rsp_free, all_empty
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_str_id, cmd_width, rsp_ready,
        output cmd_ready, rsp_valid, rsp_ok, rsp_height, rsp_free, all_empty
    );
endinterface

// File: rtl/row_occupancy_tracker.sv
// Tracks free width per row for alloc/release commands and maps str_id to row height.
// One command in flight at a time: IDLE -> LOOK -> UPD -> RESP -> IDLE.
module row_occupancy_tracker #(
    parameter int ROW_WIDTH = 16,
    parameter int NUM_ROWS  = 13
) (
    input  logic                    clk,
    input  logic                    rst,
    row_occupancy_tracker_if.slave  bus,
    output logic [1:0]              dbg_state
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOOK = 2'd1,
        UPD  = 2'd2,
        RESP = 2'd3
    } state_e;

    localparam logic [4:0] ROW_W5 = 5'(ROW_WIDTH);
    localparam logic [5:0] ROW_W6 = 6'(ROW_WIDTH);

    state_e     state_q, state_d;
    logic       op_q, op_d;
    logic [3:0] id_q, id_d;
    logic [4:0] width_q, width_d;
    logic       ok_q, ok_d;
    logic [4:0] height_q, height_d;
    logic [4:0] cur_q, cur_d;
    logic [4:0] new_q, new_d;
    logic       cmd_ready_q, cmd_ready_d;
    logic       rsp_valid_q, rsp_valid_d;
    logic       rsp_ok_q, rsp_ok_d;
    logic [4:0] rsp_height_q, rsp_height_d;
    logic [4:0] rsp_free_q, rsp_free_d;
    logic       all_empty_q, all_empty_d;
    logic [4:0] free_q [1:NUM_ROWS];
    logic [4:0] free_d [1:NUM_ROWS];

    logic       id_valid;
    logic [4:0] rd_free;
    logic [5:0] sum6;

    function automatic logic [4:0] row_height(input logic [3:0] id);
        case (id)
            4'd1, 4'd2:          row_height = 5'd8;
            4'd3:                row_height = 5'd9;
            4'd4:                row_height = 5'd7;
            4'd5:                row_height = 5'd10;
            4'd6:                row_height = 5'd6;
            4'd7:                row_height = 5'd11;
            4'd8:                row_height = 5'd5;
            4'd9:                row_height = 5'd12;
            4'd10:               row_height = 5'd4;
            4'd11, 4'd12, 4'd13: row_height = 5'd16;
            default:             row_height = 5'd0;
        endcase
    endfunction

    // Lookup of the captured row; an invalid id reads as zero free width.
    always_comb begin
        id_valid = (id_q != 4'd0) && (id_q <= 4'(NUM_ROWS));
        rd_free  = 5'd0;
        for (int i = 1; i <= NUM_ROWS; i++) begin
            if (id_q == 4'(i)) rd_free = free_q[i];
        end
        sum6 = {1'b0, rd_free} + {1'b0, width_q};
    end

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        id_d         = id_q;
        width_d      = width_q;
        ok_d         = ok_q;
        height_d     = height_q;
        cur_d        = cur_q;
        new_d        = new_q;
        cmd_ready_d  = cmd_ready_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_ok_d     = rsp_ok_q;
        rsp_height_d = rsp_height_q;
        rsp_free_d   = rsp_free_q;
        for (int i = 1; i <= NUM_ROWS; i++) free_d[i] = free_q[i];

        all_empty_d = 1'b1;
        for (int i = 1; i <= NUM_ROWS; i++) begin
            if (free_q[i] != ROW_W5) all_empty_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (bus.cmd_valid && cmd_ready_q) begin
                    op_d        = bus.cmd_op;
                    id_d        = bus.cmd_str_id;
                    width_d     = bus.cmd_width;
                    cmd_ready_d = 1'b0;
                    state_d     = LOOK;
                end
            end
            LOOK: begin
                height_d = id_valid ? row_height(id_q) : 5'd0;
                cur_d    = rd_free;
                new_d    = rd_free;
                if (!id_valid) begin
                    ok_d = 1'b0;
                end else if (width_q == 5'd0) begin
                    ok_d = 1'b1;
                end else if (!op_q) begin
                    ok_d  = (width_q <= rd_free);
                    new_d = rd_free - width_q;
                end else begin
                    // Release compares in 6 bits so an overflowing sum is rejected, never wrapped.
                    ok_d  = (sum6 <= ROW_W6);
                    new_d = sum6[4:0];
                end
                state_d = UPD;
            end
            UPD: begin
                for (int i = 1; i <= NUM_ROWS; i++) begin
                    if (ok_q && (id_q == 4'(i))) free_d[i] = new_q;
                end
                rsp_ok_d     = ok_q;
                rsp_height_d = height_q;
                rsp_free_d   = ok_q ? new_q : cur_q;
                rsp_valid_d  = 1'b1;
                state_d      = RESP;
            end
            RESP: begin
                if (rsp_valid_q && bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            op_q         <= 1'b0;
            id_q         <= 4'd0;
            width_q      <= 5'd0;
            ok_q         <= 1'b0;
            height_q     <= 5'd0;
            cur_q        <= 5'd0;
            new_q        <= 5'd0;
            cmd_ready_q  <= 1'b1;
            rsp_valid_q  <= 1'b0;
            rsp_ok_q     <= 1'b0;
            rsp_height_q <= 5'd0;
            rsp_free_q   <= 5'd0;
            all_empty_q  <= 1'b1;
            for (int i = 1; i <= NUM_ROWS; i++) free_q[i] <= ROW_W5;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            id_q         <= id_d;
            width_q      <= width_d;
            ok_q         <= ok_d;
            height_q     <= height_d;
            cur_q        <= cur_d;
            new_q        <= new_d;
            cmd_ready_q  <= cmd_ready_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_ok_q     <= rsp_ok_d;
            rsp_height_q <= rsp_height_d;
            rsp_free_q   <= rsp_free_d;
            all_empty_q  <= all_empty_d;
            for (int i = 1; i <= NUM_ROWS; i++) free_q[i] <= free_d[i];
        end
    end

    assign bus.cmd_ready  = cmd_ready_q;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_ok     = rsp_ok_q;
    assign bus.rsp_height = rsp_height_q;
    assign bus.rsp_free   = rsp_free_q;
    assign bus.all_empty  = all_empty_q;
    assign dbg_state      = state_q;
endmodule
